o_serdes_clk_mc: RTL and testbench
==================================

# o_serdes_clk_mc

Multi-channel, fully synchronous output-serializer clock generator. It derives up to NUM_CH forwarded clocks from PLL_CLK by integer division, with per-channel quarter-period phase offset and glitch-free per-channel gating. Output starts only after a programmable lock-settle interval. It sits between the PLL and the output buffer / O_DELAY of each serializer lane, and replaces the single-channel behavioural clock model with synthesizable RTL.

## Interface
- NUM_CH, 2: number of output clock channels (1–16).
- DIV, 2: half-period base in PLL_CLK cycles; even, ≥2.
- DATA_RATE, "SDR": "SDR" or "DDR". Output period P = 2·DIV (SDR) or 4·DIV (DDR), in PLL_CLK cycles.
- LOCK_WAIT, 256: PLL_CLK cycles PLL_LOCK must stay high before output enables (≥2).
- Illegal DATA_RATE, odd DIV or LOCK_WAIT<2: elaboration-time $error.

Clock is PLL_CLK; reset is synchronous and active-high.

- PLL_CLK  in  1  sole clock; all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- PLL_LOCK  in  1  PLL lock, synchronous to PLL_CLK.
- CLK_EN  in  NUM_CH  per-channel enable request.
- PHASE  in  2·NUM_CH  per-channel phase code: 0=0°, 1=90°, 2=180°, 3=270°.
- OUTPUT_CLK  out  NUM_CH  registered forwarded clocks.
- READY  out  1  high while in RUN.

## Operation
- FSM states:
  - IDLE: entered on reset.
  - WAIT: lock-settle count.
  - RUN: clocks generated.
- Transitions:
  - IDLE→WAIT when PLL_LOCK=1.
  - WAIT→RUN when the wait counter reaches LOCK_WAIT.
  - Any state→IDLE when PLL_LOCK=0. This has priority over all else.
- Wait counter:
  - Cleared in IDLE.
  - Increments every WAIT cycle; width clog2(LOCK_WAIT+1).
- Phase counter cnt, width clog2(P):
  - Held at 0 outside RUN.
  - In RUN, increments mod P; wraps P−1→0.
- Per-channel offset OFF_i = PHASE_i·P/4, exact because DIV is even.
- Per-channel position pos_i = (cnt − OFF_i) mod P.
- Per-channel gate_i:
  - Loads CLK_EN[i] only in RUN cycles where pos_i = P−1.
  - Cleared outside RUN.
  - Enable and disable therefore always take effect at that channel's period boundary. No runt or truncated pulse is ever produced.
- Per-channel latched phase ph_i:
  - Loads PHASE_i in any cycle where gate_i=0, including outside RUN.
  - Frozen while gate_i=1. A PHASE change while running is ignored until the channel is gated off.
  - OFF_i is computed from ph_i.
- OUTPUT_CLK[i] is registered: next value = RUN ∧ gate_i ∧ (pos_i < P/2), evaluated with current cnt and gate_i.
- READY is registered and equals (state==RUN).

## Timing
- Reset values: OUTPUT_CLK=0, READY=0, state=IDLE, cnt=0, wait counter=0, gate=0, ph_i=0.
- Lock to READY:
  - Let edge E0 be the first edge that samples PLL_LOCK=1 in IDLE.
  - READY=1 after edge E0+LOCK_WAIT; cnt=0 in that first RUN cycle.
- Enable latency: gate_i=1 is loaded at the edge ending the cycle with pos_i=P−1. OUTPUT_CLK[i] rises one edge later, when pos_i=0 is registered, and holds high P/2 cycles.
- Duty cycle is exactly 50%. Channel i rising edge lags the 0° channel by OFF_i PLL_CLK cycles.
- Disable: the current period completes fully. The output is low from the next boundary onward.
- PLL_LOCK deassert in RUN:
  - The next edge forces state=IDLE and READY=0.
  - OUTPUT_CLK goes to 0 on the following edge. A high phase may be truncated; this is the only permitted truncation.
- PLL_LOCK low for any single cycle in WAIT restarts the full LOCK_WAIT count.
- RST has priority over PLL_LOCK. When asserted mid-RUN, all outputs are 0 after the next edge.
- Simultaneous gate load and PHASE change: the gate loads the new enable. PHASE is taken only if the gate was 0 in that cycle.

## Test plan
- Bench configuration: DIV=2, SDR (P=4), LOCK_WAIT=8, NUM_CH=2.
- Reset then lock: RST 3 cycles, PLL_LOCK=1 at E0 → READY=1 exactly after E0+8. OUTPUT_CLK stays 0 throughout.
- Run, 0°/90° channels: CLK_EN=2'b11, PHASE={1,0} → ch0 pattern 1100 repeating. ch1 is identical but delayed 1 PLL_CLK cycle. 50% duty is checked over 100 periods.
- Mid-period gating: drop CLK_EN[0] in the 2nd high cycle → the pulse still completes 2 cycles high, then stays 0. Re-raising CLK_EN mid-period → the first high is aligned to the boundary, with no runt.
- Phase change while running: PHASE_0 goes 0→2 with gate on → no effect. Gate off, change to 2, gate on → ch0 lags 2 cycles.
- Lock loss: PLL_LOCK drops in RUN → READY=0 after 1 edge, OUTPUT_CLK=0 after 2 edges. A 1-cycle lock glitch at WAIT count 5 → READY delayed to 8 cycles after re-lock.
- DDR variant: DDR, DIV=2 → period 8, 4 high / 4 low. A 270° channel lags 6 cycles.

Source files
------------

// File: rtl/o_serdes_clk_mc.sv
// rtl/o_serdes_clk_mc.sv - multi-channel forwarded-clock generator: integer division, quarter-period phase, glitch-free gating
module o_serdes_clk_mc #(
    parameter int NUM_CH    = 2,
    parameter int DIV       = 2,
    parameter     DATA_RATE = "SDR",
    parameter int LOCK_WAIT = 256
) (
    input  logic                  PLL_CLK,
    input  logic                  RST,
    input  logic                  PLL_LOCK,
    input  logic [NUM_CH-1:0]     CLK_EN,
    input  logic [2*NUM_CH-1:0]   PHASE,
    output logic [NUM_CH-1:0]     OUTPUT_CLK,
    output logic                  READY
);

    localparam bit IS_DDR = (DATA_RATE == "DDR");
    localparam int P      = IS_DDR ? 4 * DIV : 2 * DIV;
    localparam int CW     = $clog2(P);
    localparam int WW     = $clog2(LOCK_WAIT + 1);

    localparam logic [CW-1:0] P_M1  = CW'(P - 1);
    localparam logic [CW-1:0] P_C   = CW'(P);
    localparam logic [CW-1:0] HALF  = CW'(P / 2);
    localparam logic [CW-1:0] QTR   = CW'(P / 4);
    localparam logic [WW-1:0] LW_M1 = WW'(LOCK_WAIT - 1);

    if ((DATA_RATE != "SDR") && (DATA_RATE != "DDR")) begin : g_bad_rate
        $error("o_serdes_clk_mc: DATA_RATE must be \"SDR\" or \"DDR\"");
    end
    if ((DIV < 2) || (DIV % 2 != 0)) begin : g_bad_div
        $error("o_serdes_clk_mc: DIV must be even and >= 2");
    end
    if (LOCK_WAIT < 2) begin : g_bad_wait
        $error("o_serdes_clk_mc: LOCK_WAIT must be >= 2");
    end
    if ((NUM_CH < 1) || (NUM_CH > 16)) begin : g_bad_ch
        $error("o_serdes_clk_mc: NUM_CH must be 1..16");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RUN
    } state_t;

    state_t                        state;
    state_t                        state_nxt;
    logic [WW-1:0]                 wcnt;
    logic [CW-1:0]                 cnt;
    logic [NUM_CH-1:0]             gate;
    logic [NUM_CH-1:0][1:0]        ph;
    logic [NUM_CH-1:0][CW-1:0]     off;
    logic [NUM_CH-1:0][CW-1:0]     pos;

    always_ff @(posedge PLL_CLK) begin
        if (RST) begin
            state <= ST_IDLE;
            READY <= 1'b0;
        end else begin
            state <= state_nxt;
            READY <= (state_nxt == ST_RUN);
        end
    end

    // Lock loss overrides every other transition.
    always_comb begin
        state_nxt = state;
        if (!PLL_LOCK) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: state_nxt = ST_WAIT;
                ST_WAIT: if (wcnt == LW_M1) state_nxt = ST_RUN;
                ST_RUN:  state_nxt = ST_RUN;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge PLL_CLK) begin
        if (RST || (state != ST_WAIT)) begin
            wcnt <= '0;
        end else begin
            wcnt <= wcnt + WW'(1);
        end
    end

    always_ff @(posedge PLL_CLK) begin
        if (RST || (state != ST_RUN)) begin
            cnt <= '0;
        end else if (cnt == P_M1) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    // Position within each channel's own period; the wrap add is exact modulo 2**CW.
    always_comb begin
        off = '0;
        pos = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            off[i] = CW'(ph[i]) * QTR;
            pos[i] = (cnt >= off[i]) ? (cnt - off[i]) : (cnt + P_C - off[i]);
        end
    end

    always_ff @(posedge PLL_CLK) begin
        if (RST) begin
            gate       <= '0;
            ph         <= '0;
            OUTPUT_CLK <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gate[i]) begin
                    ph[i] <= PHASE[2*i +: 2];
                end
                if (state != ST_RUN) begin
                    gate[i] <= 1'b0;
                end else if (pos[i] == P_M1) begin
                    gate[i] <= CLK_EN[i];
                end
                OUTPUT_CLK[i] <= (state == ST_RUN) && gate[i] && (pos[i] < HALF);
            end
        end
    end

endmodule

// File: tb/tb_o_serdes_clk_mc.sv
// tb/tb_o_serdes_clk_mc.sv - self-checking bench for o_serdes_clk_mc (SDR and DDR instances)
module tb_o_serdes_clk_mc;

    localparam int LW = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic [1:0] en = 2'b00;
    logic [3:0] phase = 4'b0000;
    logic [1:0] out_s;
    logic [1:0] out_d;
    logic       rdy_s;
    logic       rdy_d;

    always #5 clk = ~clk;

    o_serdes_clk_mc #(.NUM_CH(2), .DIV(2), .DATA_RATE("SDR"), .LOCK_WAIT(LW)) dut (
        .PLL_CLK(clk), .RST(rst), .PLL_LOCK(lock), .CLK_EN(en), .PHASE(phase),
        .OUTPUT_CLK(out_s), .READY(rdy_s)
    );

    o_serdes_clk_mc #(.NUM_CH(2), .DIV(2), .DATA_RATE("DDR"), .LOCK_WAIT(LW)) dut_ddr (
        .PLL_CLK(clk), .RST(rst), .PLL_LOCK(lock), .CLK_EN(en), .PHASE(phase),
        .OUTPUT_CLK(out_d), .READY(rdy_d)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: time since lock is a streak of lock-high edges; phase counter is derived from it.
    int       streak = 0;
    bit       m_ready = 1'b0;
    bit       m_gate [2][2];
    bit [1:0] m_ph   [2][2];
    bit       m_out  [2][2];

    function automatic int period_of(input int k);
        return (k == 0) ? 4 : 8;
    endfunction

    task automatic model_step(input bit r, input bit l, input bit [1:0] e, input bit [3:0] ph_in);
        if (r) begin
            streak  = 0;
            m_ready = 1'b0;
            for (int k = 0; k < 2; k++) begin
                for (int c = 0; c < 2; c++) begin
                    m_gate[k][c] = 1'b0;
                    m_ph[k][c]   = 2'd0;
                    m_out[k][c]  = 1'b0;
                end
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                int p;
                bit run;
                int tc;
                p   = period_of(k);
                run = (streak > LW);
                tc  = run ? ((streak - LW - 1) % p) : 0;
                for (int c = 0; c < 2; c++) begin
                    int off;
                    int pos;
                    off = int'(m_ph[k][c]) * p / 4;
                    pos = (tc - off + p) % p;
                    m_out[k][c] = run && m_gate[k][c] && (pos < p / 2);
                    if (!m_gate[k][c]) m_ph[k][c] = ph_in[2*c +: 2];
                    if (!run) m_gate[k][c] = 1'b0;
                    else if (pos == p - 1) m_gate[k][c] = e[c];
                end
            end
            streak  = l ? streak + 1 : 0;
            m_ready = (streak > LW);
        end
    endtask

    task automatic cycle(input bit r, input bit l, input bit [1:0] e, input bit [3:0] ph);
        rst = r; lock = l; en = e; phase = ph;
        @(posedge clk);
        model_step(r, l, e, ph);
        @(negedge clk);
        check("sdr_out",   int'(out_s), int'({m_out[0][1], m_out[0][0]}));
        check("sdr_ready", int'(rdy_s), int'(m_ready));
        check("ddr_out",   int'(out_d), int'({m_out[1][1], m_out[1][0]}));
        check("ddr_ready", int'(rdy_d), int'(m_ready));
    endtask

    typedef struct {
        bit       r;
        bit       l;
        bit [1:0] e;
        bit [3:0] ph;
        bit [1:0] eo;
        bit       er;
    } vec_t;

    vec_t     tbl [22];
    bit [1:0] exp_run [11];

    initial begin
        int  cnt0, cnt1, f, mism, highs;
        bit  prev, found;
        bit  s0 [48];
        bit  s1 [48];

        exp_run = '{2'b00, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01, 2'b11};
        for (int i = 0; i < 22; i++) begin
            if (i < 3)       tbl[i] = '{1'b1, 1'b0, 2'b11, 4'b0100, 2'b00, 1'b0};
            else if (i < 11) tbl[i] = '{1'b0, 1'b1, 2'b11, 4'b0100, 2'b00, 1'b0};
            else             tbl[i] = '{1'b0, 1'b1, 2'b11, 4'b0100, exp_run[i-11], 1'b1};
        end

        // Reset, lock settle, first periods of 0/90 degree channels.
        for (int i = 0; i < 22; i++) begin
            cycle(tbl[i].r, tbl[i].l, tbl[i].e, tbl[i].ph);
            check("tbl_out",   int'(out_s), int'(tbl[i].eo));
            check("tbl_ready", int'(rdy_s), int'(tbl[i].er));
        end

        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 400; i++) begin
            cycle(1'b0, 1'b1, 2'b11, 4'b0100);
            cnt0 += int'(out_s[0]);
            cnt1 += int'(out_s[1]);
        end
        check("duty_ch0", cnt0, 200);
        check("duty_ch1", cnt1, 200);

        // Drop enable during a high phase: pulse completes, then stays low.
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            prev = out_s[0];
            cycle(1'b0, 1'b1, 2'b11, 4'b0100);
            if (!prev && out_s[0]) found = 1'b1;
        end
        check("gate_rise_found", int'(found), 1);
        cycle(1'b0, 1'b1, 2'b10, 4'b0100);
        check("gate_off_2nd_high", int'(out_s[0]), 1);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, 2'b10, 4'b0100);
            check("gate_off_low", int'(out_s[0]), 0);
        end

        // Re-enable mid-period: first high aligned to the boundary, full width.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 2'b11, 4'b0100);
            s0[i] = out_s[0];
        end
        f = -1;
        for (int i = 11; i >= 0; i--) if (s0[i]) f = i;
        check("reenable_first_high", f, 2);
        check("reenable_w1", int'(s0[3]), 1);
        check("reenable_l0", int'(s0[4]), 0);
        check("reenable_l1", int'(s0[5]), 0);
        check("reenable_h2", int'(s0[6]), 1);

        // Phase change with gate on is ignored.
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 2'b11, 4'b0110);
            s0[i] = out_s[0]; s1[i] = out_s[1];
        end
        mism = 0;
        for (int t = 0; t < 11; t++) if (s0[t] != s1[t+1]) mism++;
        check("phase_frozen", mism, 0);

        // Gate off, new phase latched, gate on: 180 deg channel lags 90 deg by 1.
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 2'b10, 4'b0110);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 2'b11, 4'b0110);
        highs = 0; mism = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b0, 1'b1, 2'b11, 4'b0110);
            s0[i] = out_s[0]; s1[i] = out_s[1];
            highs += int'(out_s[0]);
        end
        for (int t = 0; t < 11; t++) if (s1[t] != s0[t+1]) mism++;
        check("phase_180_lag", mism, 0);
        check("phase_180_highs", highs, 6);

        // Reset mid-run clears everything after one edge.
        cycle(1'b1, 1'b1, 2'b11, 4'b1100);
        check("rst_out_sdr", int'(out_s), 0);
        check("rst_out_ddr", int'(out_d), 0);
        check("rst_ready", int'(rdy_s), 0);

        // One-cycle lock glitch at wait count 5 restarts the settle count.
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b1, 2'b11, 4'b1100);
        cycle(1'b0, 1'b0, 2'b11, 4'b1100);
        for (int j = 0; j <= 8; j++) begin
            cycle(1'b0, 1'b1, 2'b11, 4'b1100);
            check("relock_ready", int'(rdy_s), (j == 8) ? 1 : 0);
        end

        // DDR: period 8, 270 deg channel lags 6 cycles.
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 2'b11, 4'b1100);
        highs = 0; mism = 0;
        for (int i = 0; i < 48; i++) begin
            cycle(1'b0, 1'b1, 2'b11, 4'b1100);
            s0[i] = out_d[0]; s1[i] = out_d[1];
            if (i < 40) highs += int'(out_d[0]);
        end
        for (int t = 0; t < 42; t++) if (s0[t] != s1[t+6]) mism++;
        check("ddr_270_lag", mism, 0);
        check("ddr_duty", highs, 20);

        // Lock loss in RUN: READY falls after one edge, clocks after two.
        cycle(1'b0, 1'b0, 2'b11, 4'b1100);
        check("lockloss_ready", int'(rdy_s), 0);
        cycle(1'b0, 1'b0, 2'b11, 4'b1100);
        check("lockloss_out_sdr", int'(out_s), 0);
        check("lockloss_out_ddr", int'(out_d), 0);

        // Randomized traffic against the reference.
        for (int i = 0; i < 3000; i++) begin
            bit       r, l;
            bit [1:0] e;
            bit [3:0] ph;
            r  = ($urandom_range(0, 499) == 0);
            l  = ($urandom_range(0, 199) != 0);
            e  = ($urandom_range(0, 15) == 0) ? 2'($urandom) : en;
            ph = ($urandom_range(0, 7) == 0) ? 4'($urandom) : phase;
            cycle(r, l, e, ph);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
